// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl
//   Refresh scanner for a 4-digit multiplexed segment display. A prescaler
//   paces the digit slot select; a one-deep pending buffer accepts new
//   segment words at any time. The active word is swapped only at frame
//   boundaries, so a scan frame never shows a mix of old and new digits.
//
//   Optional feature: define DIGIT_SCAN_BLINK_EN to add a frame counter and
//   blink phase that darken the display on alternate BLINK_FRAMES periods
//   while the blink input is high.
//
// Parameters
//   REFRESH_DIV  - clocks per digit slot (2 .. 2^20)
//   BLINK_FRAMES - frames per blink half-period (DIGIT_SCAN_BLINK_EN only)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   word_in    in   [27:0] new word, digit 0 in [27:21], digit 3 in [6:0], active-low
//   load_valid in   load request for word_in
//   load_ready out  pending buffer empty, load can be accepted
//   blank      in   force all segments off
//   blink      in   blink request (DIGIT_SCAN_BLINK_EN only)
//   word       out  [27:0] word to the downstream digit/anode mux
//   sel        out  [1:0] digit slot select
//   frame_done out  one-cycle pulse after each frame boundary
//   load_done  out  one-cycle pulse after a pending word becomes active
module digit_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [27:0] word_in,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic        blank,
    input  logic        blink,
    output logic [27:0] word,
    output logic [1:0]  sel,
    output logic        frame_done,
    output logic        load_done
);

    localparam logic [27:0] DARK    = 28'hFFFFFFF;
    // 20 bits hold REFRESH_DIV-1 for the whole legal range up to 2^20.
    localparam logic [19:0] CNT_MAX = 20'(REFRESH_DIV - 1);

    logic [19:0] cnt;
    logic [27:0] active;
    logic [27:0] pend;
    logic        pend_full;
    logic        tick;
    logic        boundary;
    logic        accept;
    logic        dark;

    assign tick       = (cnt == CNT_MAX);
    assign boundary   = tick && (sel == 2'd3);
    assign load_ready = ~pend_full;
    assign accept     = load_valid && load_ready;

    // Control state: prescaler, slot select, pending flag, active word, pulses.
    // A load accepted on a boundary cycle only fills pending (pend_full was
    // clear, so no transfer happens that cycle) and applies one frame later.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            sel        <= 2'd0;
            active     <= DARK;
            pend_full  <= 1'b0;
            frame_done <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + 20'd1;
            if (tick) begin
                sel <= sel + 2'd1;
            end
            frame_done <= boundary;
            load_done  <= boundary && pend_full;
            if (boundary && pend_full) begin
                active    <= pend;
                pend_full <= 1'b0;
            end
            if (accept) begin
                pend_full <= 1'b1;
            end
        end
    end

    // Pending data is qualified by pend_full, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend <= word_in;
        end
    end

`ifdef DIGIT_SCAN_BLINK_EN
    localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FR_W-1:0] FR_MAX = FR_W'(BLINK_FRAMES - 1);

    logic [FR_W-1:0] frame_cnt;
    logic            blink_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (boundary) begin
            if (frame_cnt == FR_MAX) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign dark = blank || (blink && blink_phase);
`else
    // Blink hardware is absent; keep the input and parameter visibly consumed.
    logic [31:0] unused_blink_cfg;
    assign unused_blink_cfg = 32'(BLINK_FRAMES) ^ {31'd0, blink};

    assign dark = blank;
`endif

    assign word = dark ? DARK : active;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl with REFRESH_DIV=4, BLINK_FRAMES=2. A cycle-level
// reference model derived from elapsed time since reset (slot = time/4 mod 4,
// boundary every 16 clocks) and a one-entry pending queue predicts every
// output; directed scenarios are followed by randomized traffic.
module tb_digit_scan_ctrl;

    localparam int          RD    = 4;
    localparam int          BF    = 2;
    localparam int          FRAME = 4 * RD;
    localparam logic [27:0] DARK  = 28'hFFFFFFF;

    logic        clk;
    logic        reset;
    logic [27:0] word_in;
    logic        load_valid;
    logic        load_ready;
    logic        blank;
    logic        blink;
    logic [27:0] word;
    logic [1:0]  sel;
    logic        frame_done;
    logic        load_done;

    digit_scan_ctrl #(
        .REFRESH_DIV (RD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .word_in   (word_in),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .blank     (blank),
        .blink     (blink),
        .word      (word),
        .sel       (sel),
        .frame_done(frame_done),
        .load_done (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int unsigned  cyc;          // clocks since reset released
    logic [27:0]  m_pend[$];    // pending buffer, at most one entry
    logic [27:0]  m_active;
    logic         m_fd;
    logic         m_ld;
    int           m_frames;
    logic         m_phase;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [27:0] exp_word();
        if (blank) return DARK;
`ifdef DIGIT_SCAN_BLINK_EN
        if (blink && m_phase) return DARK;
`endif
        return m_active;
    endfunction

    // One clock: update the model with the inputs seen at the edge, then
    // compare every output on the falling edge.
    task automatic step();
        bit boundary;
        @(posedge clk);
        if (reset) begin
            cyc      = 0;
            m_pend   = {};
            m_active = DARK;
            m_fd     = 1'b0;
            m_ld     = 1'b0;
            m_frames = 0;
            m_phase  = 1'b0;
        end else begin
            boundary = ((cyc % FRAME) == FRAME - 1);
            m_fd = boundary;
            m_ld = boundary && (m_pend.size() != 0);
            if (m_ld) m_active = m_pend.pop_front();
            else if (load_valid && m_pend.size() == 0) m_pend.push_back(word_in);
            if (boundary) begin
                m_frames++;
                if (m_frames == BF) begin
                    m_frames = 0;
                    m_phase  = ~m_phase;
                end
            end
            cyc++;
        end
        @(negedge clk);
        check_val("sel",        {30'd0, sel},        (cyc / RD) % 4);
        check_val("word",       {4'd0, word},        {4'd0, exp_word()});
        check_val("load_ready", {31'd0, load_ready}, {31'd0, (m_pend.size() == 0)});
        check_val("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
        check_val("load_done",  {31'd0, load_done},  {31'd0, m_ld});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the model clock sits at the given phase within a frame.
    task automatic step_to_phase(input int unsigned ph);
        for (int i = 0; i < FRAME; i++) begin
            if ((cyc % FRAME) == ph) break;
            step();
        end
    endtask

    task automatic load_once(input logic [27:0] w);
        word_in    = w;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        word_in    = '0;
        load_valid = 1'b0;
        blank      = 1'b0;
        blink      = 1'b0;
        cyc        = 0;
        m_active   = DARK;
        m_fd       = 1'b0;
        m_ld       = 1'b0;
        m_frames   = 0;
        m_phase    = 1'b0;

        // Reset state, including a load request that reset must override
        word_in    = 28'h1234567;
        load_valid = 1'b1;
        steps(2);
        load_valid = 1'b0;
        reset      = 1'b0;

        // Free-running scan with no loads
        steps(40);

        // Mid-frame load
        step_to_phase(5);
        load_once(28'h0000001);
        steps(24);

        // Second request while not ready is dropped
        step_to_phase(3);
        load_once(28'h1111111);
        word_in    = 28'h2222222;
        load_valid = 1'b1;
        steps(3);
        load_valid = 1'b0;
        steps(20);

        // Load in the exact boundary cycle defers one whole frame
        step_to_phase(FRAME - 1);
        load_once(28'h3333333);
        steps(36);

        // Reset at cnt=2, sel=2 with a word pending
        step_to_phase(8);
        load_once(28'h4444444);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        steps(24);

        // Blank overrides the word without disturbing the scan
        load_once(28'h5555555);
        steps(20);
        blank = 1'b1;
        steps(20);
        blank = 1'b0;
        steps(4);

        // Blink held with an active word, then combined with blank
        blink = 1'b1;
        steps(80);
        blank = 1'b1;
        steps(40);
        blank = 1'b0;
        blink = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            word_in    = 28'($urandom);
            load_valid = ($urandom_range(0, 5) == 0);
            blank      = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) blink = ~blink;
            reset      = ($urandom_range(0, 499) == 0);
            step();
        end
        reset      = 1'b0;
        load_valid = 1'b0;
        steps(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
